uart_hex_loader: RTL and testbench

Byte-stream parser between the UART receiver and the CPU instruction memory. Consumes received bytes over the receiver's rdy/rdy_clr handshake, echoes each one back through the UART transmitter, and assembles ASCII hex digits into 32-bit words. Each completed word is written to consecutive instruction-memory locations, so a program can be typed or streamed in before the CPU is started.

---
 rtl/uart_hex_loader_pkg.sv | 22 ++
 rtl/hex_char_decode.sv | 31 +++
 rtl/uart_hex_loader.sv | 135 +++++++++++++
 tb/tb_uart_hex_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_hex_loader_pkg.sv
// Shared types and constants for the UART hex loader.
package uart_hex_loader_pkg;

    // Loader sequencing: wait for a byte, acknowledge/echo it, optionally write a word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Character codes with special meaning in the input stream.
    localparam logic [7:0] CHAR_CLEAR = 8'h21;  // '!'
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_TAB   = 8'h09;

    localparam int WORD_W        = 32;
    localparam int NIBS_PER_WORD = 8;
    localparam int NIB_CNT_W     = $clog2(NIBS_PER_WORD);

endpackage

// File: rtl/hex_char_decode.sv
// Combinational classifier for one received byte: hex digit (with its value),
// whitespace, or the clear character. Anything else is reported by none of the flags.
module hex_char_decode
    import uart_hex_loader_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_hex,
    output logic       is_ws,
    output logic       is_clear,
    output logic [3:0] nib
);

    // Classify the byte and convert ASCII hex to its 4-bit value.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        is_hex   = 1'b0;
        nib      = 4'h0;
        is_ws    = (rx_data == CHAR_SPACE) || (rx_data == CHAR_CR) ||
                   (rx_data == CHAR_LF)    || (rx_data == CHAR_TAB);
        is_clear = (rx_data == CHAR_CLEAR);
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin          // '0'..'9'
            is_hex = 1'b1;
            nib    = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||   // 'A'..'F'
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin // 'a'..'f'
            is_hex = 1'b1;
            nib    = rx_data[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_loader.sv
// UART hex loader: consumes bytes from the UART receiver, echoes them to the
// transmitter, assembles ASCII hex digits MSB-first into 32-bit words and writes
// each completed word to consecutive instruction-memory addresses.
// Optional feature macro: UART_HEX_LOADER_ECHO_EN (echo enabled, tx_busy gates accept).
// Without it, tx_wr_en/tx_din are tied low and tx_busy is ignored.
module uart_hex_loader
    import uart_hex_loader_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              rx_rdy_clr,
    input  logic              tx_busy,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err,
    output logic [3:0]        last_nib
);

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      word_q;
    logic [NIB_CNT_W-1:0]   nib_cnt_q;
    logic                   word_done_q;
    logic                   err_q;
    logic [3:0]             last_nib_q;
    logic [ADDR_W:0]        word_count_q;
    logic                   accept;

    logic                   is_hex, is_ws, is_clear;
    logic [3:0]             nib;

    hex_char_decode u_decode (
        .rx_data  (rx_data),
        .is_hex   (is_hex),
        .is_ws    (is_ws),
        .is_clear (is_clear),
        .nib      (nib)
    );

`ifdef UART_HEX_LOADER_ECHO_EN
    logic [7:0] tx_din_q;

    // rx_rdy_clr blocks a re-accept while the receiver is still clearing rx_rdy.
    assign accept = rx_rdy && !tx_busy && !rx_rdy_clr && !mem_we;

    // Capture the echo byte on accept; it is presented during the ACK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      tx_din_q <= 8'h00;
        else if (accept) tx_din_q <= rx_data;
    end
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign accept         = rx_rdy && !rx_rdy_clr && !mem_we;
`endif

    // Memory becomes full once word_count reaches 2**ADDR_W; '!' clears both together.
    assign full       = word_count_q[ADDR_W];
    assign word_count = word_count_q;
    assign mem_addr   = word_count_q[ADDR_W-1:0];
    assign mem_wdata  = word_q;
    assign err        = err_q;
    assign last_nib   = last_nib_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: ACK always follows an accept, WRITE only if a word completed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACK;
            ACK:     state_d = word_done_q ? WRITE : IDLE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output strobes are decoded from the registered state, so each lasts exactly one cycle.
    always_comb begin
        rx_rdy_clr = (state_q == ACK);
        mem_we     = (state_q == WRITE);
`ifdef UART_HEX_LOADER_ECHO_EN
        tx_wr_en   = (state_q == ACK);
        tx_din     = tx_din_q;
`else
        tx_wr_en   = 1'b0;
        tx_din     = 8'h00;
`endif
    end

    // Character processing on accept, and word_count advance on the write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q       <= '0;
            nib_cnt_q    <= '0;
            word_done_q  <= 1'b0;
            err_q        <= 1'b0;
            last_nib_q   <= 4'h0;
            word_count_q <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments make every read here see the pre-edge value,
            // so the nib_cnt test below refers to the count before this nibble.
            word_done_q <= 1'b0;
            if (is_hex) begin
                word_q      <= {word_q[WORD_W-5:0], nib};
                nib_cnt_q   <= nib_cnt_q + 1'b1;  // wraps to 0 after the 8th nibble
                last_nib_q  <= nib;
                word_done_q <= (nib_cnt_q == NIB_CNT_W'(NIBS_PER_WORD - 1)) && !full;
            end else if (is_clear) begin
                word_q       <= '0;
                nib_cnt_q    <= '0;
                word_count_q <= '0;
                err_q        <= 1'b0;
            end else if (!is_ws) begin
                err_q     <= 1'b1;
                nib_cnt_q <= '0;
            end
        end else if (state_q == WRITE && !full) begin
            word_count_q <= word_count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_hex_loader.sv
// Self-checking bench for uart_hex_loader. A character-level reference model
// predicts the echo stream, the memory writes and the status outputs.
module tb_uart_hex_loader;

`ifdef UART_HEX_LOADER_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif
    localparam int ADDR_W = 4;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_rdy = 1'b0;
    logic              rx_rdy_clr;
    logic              tx_busy = 1'b0;
    logic [7:0]        tx_din;
    logic              tx_wr_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              err;
    logic [3:0]        last_nib;

    uart_hex_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .tx_busy    (tx_busy),
        .tx_din     (tx_din),
        .tx_wr_en   (tx_wr_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .full       (full),
        .err        (err),
        .last_nib   (last_nib)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_word;
    int          m_nibs;
    int          m_wc;
    bit          m_err;
    logic [3:0]  m_last;
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [7:0]        exp_echo[$];

    function automatic void model_reset();
        m_word = 0; m_nibs = 0; m_wc = 0; m_err = 0; m_last = 4'h0;
        exp_addr.delete(); exp_data.delete(); exp_echo.delete();
    endfunction

    function automatic void model_char(input logic [7:0] b);
        int v;
        v = -1;
        if (b >= 8'h30 && b <= 8'h39) v = int'(b) - 48;
        else if (b >= 8'h41 && b <= 8'h46) v = int'(b) - 65 + 10;
        else if (b >= 8'h61 && b <= 8'h66) v = int'(b) - 97 + 10;
        exp_echo.push_back(b);
        if (v >= 0) begin
            m_word = (m_word << 4) | v;
            m_last = v[3:0];
            m_nibs++;
            if (m_nibs == 8) begin
                m_nibs = 0;
                if (m_wc < CAP) begin
                    exp_addr.push_back(m_wc[ADDR_W-1:0]);
                    exp_data.push_back(m_word);
                    m_wc++;
                end
            end
        end else if (b == 8'h21) begin
            m_nibs = 0; m_word = 0; m_wc = 0; m_err = 0;
        end else if (!(b == 8'h20 || b == 8'h0D || b == 8'h0A || b == 8'h09)) begin
            m_err = 1; m_nibs = 0;
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    logic        prev_clr = 1'b0;
    int          n_writes = 0;
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [31:0]       last_wdata = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_clr <= 1'b0;
        end else begin
            if (rx_rdy_clr) begin
                logic [7:0] e;
                check("clr_spacing", prev_clr, 1'b0);
                check("echo_pending", exp_echo.size() > 0, 1'b1);
                e = (exp_echo.size() > 0) ? exp_echo.pop_front() : 8'h00;
                check("tx_wr_en", tx_wr_en, ECHO);
                check("tx_din", tx_din, ECHO ? e : 8'h00);
            end else if (tx_wr_en) begin
                check("tx_wr_en_stray", tx_wr_en, 1'b0);
            end
            if (mem_we) begin
                check("we_latency", prev_clr, 1'b1);
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", mem_we, 1'b0);
                end else begin
                    check("mem_addr", mem_addr, exp_addr.pop_front());
                    check("mem_wdata", mem_wdata, exp_data.pop_front());
                end
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
                n_writes   <= n_writes + 1;
            end
            prev_clr <= rx_rdy_clr;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        model_char(b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rx_rdy_clr) got = 1'b1;
        end
        if (!got) check("accept_timeout", got, 1'b1);
        // Receiver drops rx_rdy one cycle after the clear pulse.
        @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic send_string(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_pending_writes"}, exp_addr.size(), 0);
        check({tag, "_word_count"}, word_count, m_wc);
        check({tag, "_full"}, full, m_wc == CAP);
        check({tag, "_err"}, err, m_err);
        check({tag, "_last_nib"}, last_nib, m_last);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_rdy_clr"}, rx_rdy_clr, 1'b0);
        check({tag, "_tx_wr_en"}, tx_wr_en, 1'b0);
        check({tag, "_tx_din"}, tx_din, 8'h00);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_word_count"}, word_count, '0);
        check({tag, "_full"}, full, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_last_nib"}, last_nib, 4'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0, clr_busy, clr_free;
        model_reset();
        #23 check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic word.
        w0 = n_writes;
        send_string("00500093");
        check_status("w1");
        check("w1_nwrites", n_writes - w0, 1);
        check("w1_addr_lit", last_waddr, 4'd0);
        check("w1_data_lit", last_wdata, 32'h00500093);
        check("w1_wc_lit", word_count, 5'd1);
        check("w1_nib_lit", last_nib, 4'h3);

        // Mixed case.
        send_string("deadBEEF");
        check_status("w2");
        check("w2_data_lit", last_wdata, 32'hDEADBEEF);
        check("w2_err_lit", err, 1'b0);

        // Whitespace inside a word.
        w0 = n_writes;
        send_string("12 34\r\n5678");
        check_status("ws");
        check("ws_nwrites", n_writes - w0, 1);
        check("ws_data_lit", last_wdata, 32'h12345678);

        // Illegal character discards the partial word.
        send_string("12Z34567890");
        check_status("bad");
        check("bad_err_lit", err, 1'b1);
        check("bad_addr_lit", last_waddr, 4'd3);
        check("bad_data_lit", last_wdata, 32'h34567890);

        // Fill memory, then overflow by one word.
        send_string("!");
        check_status("clr0");
        w0 = n_writes;
        for (int i = 0; i < CAP + 1; i++) send_string($sformatf("%08x", 32'hA5000000 + i));
        check_status("fill");
        check("fill_nwrites", n_writes - w0, CAP);
        check("fill_full_lit", full, 1'b1);
        check("fill_wc_lit", word_count, 5'd16);
        check("fill_addr_lit", last_waddr, 4'd15);
        check("fill_data_lit", last_wdata, 32'hA500000F);
        send_string("x");
        check("fill_err_lit", err, 1'b1);
        send_string("!");
        check_status("clr1");
        check("clr1_wc_lit", word_count, 5'd0);
        check("clr1_full_lit", full, 1'b0);
        check("clr1_err_lit", err, 1'b0);
        send_string("CAFEF00D");
        check_status("after_clr");
        check("after_clr_addr_lit", last_waddr, 4'd0);
        check("after_clr_data_lit", last_wdata, 32'hCAFEF00D);

        // tx_busy held with a pending byte.
        clr_busy = 0;
        clr_free = 0;
        model_char(8'h35);
        @(negedge clk);
        tx_busy = 1'b1;
        rx_data = 8'h35;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_rdy_clr) begin
                clr_busy++;
                @(posedge clk);
                #1 rx_rdy = 1'b0;
            end
        end
        tx_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_rdy_clr) begin
                clr_free++;
                @(posedge clk);
                #1 rx_rdy = 1'b0;
            end
        end
        check("busy_clr_while_busy", clr_busy, ECHO ? 0 : 1);
        check("busy_clr_after_release", clr_free, ECHO ? 1 : 0);
        check("busy_clr_total", clr_busy + clr_free, 1);
        check("busy_nib_lit", last_nib, 4'h5);

        // Reset after 4 nibbles.
        send_string("123");
        @(negedge clk);
        rst_n = 1'b0;
        #2 check_all_zero("midreset");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        w0 = n_writes;
        send_string("89ABCDEF");
        check_status("post_reset");
        check("post_reset_nwrites", n_writes - w0, 1);
        check("post_reset_addr_lit", last_waddr, 4'd0);
        check("post_reset_data_lit", last_wdata, 32'h89ABCDEF);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
